runner_frame_sequencer: RTL and testbench

- Per-frame controller for the player sprite in the 160x120, 3-bit-colour runner game.
- Each frame it erases the old sprite, advances its position and probes the framebuffer under the new position for obstacle colour. It then redraws the sprite.
- It owns the collided and reached_screen_end flags that end a run.
- It sits between the frame-tick generator, the framebuffer read port and the VGA plot interface.

---
 rtl/runner_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_runner_frame_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/runner_frame_sequencer.sv
// runner_frame_sequencer
//
// Per-frame controller for the player sprite of the 160x120, 3-bit colour
// runner game. Every frame it erases the sprite, advances it (x step plus
// jump arc), probes the framebuffer under the new position for obstacle
// colour and redraws it. It owns the collided / reached_screen_end flags
// that end a run.
//
// Ports:
//   clock              system clock
//   resetn             synchronous active-low reset
//   start              begin / restart a run (sampled in IDLE and DONE)
//   jump               level jump request (sampled in MOVE)
//   frame_tick         one-cycle pulse per video frame (honoured in WAIT only)
//   pix_colour         framebuffer read data for last cycle's x_out/y_out
//   plot               framebuffer write enable
//   x_out, y_out       pixel address, shared by writes and reads
//   colour_out         write colour
//   collided           sticky: obstacle colour found under the sprite
//   reached_screen_end sticky: sprite x reached X_END
//   busy               high while a frame update is in progress
//   score              frames survived (only with RUNNER_SCORE_EN, else 0)
//
// Build option: define RUNNER_SCORE_EN to enable the saturating score counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | sprite drawn, waiting for frame_tick
// ERASE | SIZE*SIZE cycles painting BG_COL over the old position
// MOVE  | 1 cycle: step x, update jump arc, set screen-end flag
// CHECK | SIZE*SIZE+1 cycles: issue read addresses, compare read data
// DRAW  | SIZE*SIZE cycles painting SPRITE_COL at the new position
// DONE  | run over, flags held, waiting for start

module runner_frame_sequencer #(
    parameter int         SIZE       = 4,
    parameter int         X_START    = 0,
    parameter int         Y_GROUND   = 100,
    parameter int         X_END      = 156,
    parameter int         STEP       = 1,
    parameter int         JUMP_H     = 12,
    parameter int         AIR_FRAMES = 16,
    parameter logic [2:0] SPRITE_COL = 3'b110,
    parameter logic [2:0] BG_COL     = 3'b000,
    parameter logic [2:0] OBST_COL   = 3'b010
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       jump,
    input  logic       frame_tick,
    input  logic [2:0] pix_colour,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       collided,
    output logic       reached_screen_end,
    output logic       busy,
    output logic [7:0] score
);

    localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int AW = $clog2(AIR_FRAMES + 1);
    localparam logic [PW-1:0] P_LAST = PW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_CHECK,
        S_DRAW,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   px_q, px_d, py_q, py_d;
    logic [PW-1:0]   px_adv, py_adv;
    logic            tail_q, tail_d;
    logic [7:0]      pos_x_q, pos_x_d;
    logic [6:0]      pos_y_q, pos_y_d;
    logic [AW-1:0]   air_q, air_d;
    logic            coll_q, coll_d;
    logic            end_q, end_d;
    logic            plot_q, plot_d;
    logic [7:0]      x_out_q, x_out_d;
    logic [6:0]      y_out_q, y_out_d;
    logic [2:0]      col_q, col_d;
    logic            busy_q, busy_d;
    logic            scan_last;
    logic            check_sample;
    logic [8:0]      x_sum;

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        tail_d    = tail_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        air_d     = air_q;
        coll_d    = coll_q;
        end_d     = end_q;

        scan_last = (px_q == P_LAST) && (py_q == P_LAST);
        // Read data lags the address by one cycle, so CHECK cycle 0 carries
        // stale data and the extra tail cycle carries the last pixel's data.
        check_sample = tail_q || (px_q != '0) || (py_q != '0);
        x_sum     = {1'b0, pos_x_q} + 9'(STEP);

        if (px_q == P_LAST) begin
            px_adv = '0;
            py_adv = py_q + 1'b1;
        end else begin
            px_adv = px_q + 1'b1;
            py_adv = py_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRAW;
                    pos_x_d = 8'(X_START);
                    pos_y_d = 7'(Y_GROUND);
                    air_d   = '0;
                    coll_d  = 1'b0;
                    end_d   = 1'b0;
                    px_d    = '0;
                    py_d    = '0;
                    tail_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d = S_ERASE;
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            S_ERASE: begin
                if (scan_last) begin
                    state_d = S_MOVE;
                end else begin
                    px_d = px_adv;
                    py_d = py_adv;
                end
            end
            S_MOVE: begin
                if (x_sum >= 9'(X_END)) begin
                    pos_x_d = 8'(X_END);
                end else begin
                    pos_x_d = x_sum[7:0];
                end
                if (pos_x_d == 8'(X_END)) begin
                    end_d = 1'b1;
                end
                if ((air_q == '0) && jump) begin
                    pos_y_d = 7'(Y_GROUND - JUMP_H);
                    air_d   = AW'(AIR_FRAMES);
                end else if (air_q != '0) begin
                    air_d = air_q - 1'b1;
                    if (air_q == AW'(1)) begin
                        pos_y_d = 7'(Y_GROUND);
                    end
                end
                state_d = S_CHECK;
                px_d    = '0;
                py_d    = '0;
                tail_d  = 1'b0;
            end
            S_CHECK: begin
                if (check_sample && (pix_colour == OBST_COL)) begin
                    coll_d = 1'b1;
                end
                if (tail_q) begin
                    state_d = S_DRAW;
                    px_d    = '0;
                    py_d    = '0;
                    tail_d  = 1'b0;
                end else if (scan_last) begin
                    tail_d = 1'b1;
                end else begin
                    px_d = px_adv;
                    py_d = py_adv;
                end
            end
            S_DRAW: begin
                if (scan_last) begin
                    state_d = (coll_q || end_q) ? S_DONE : S_WAIT;
                end else begin
                    px_d = px_adv;
                    py_d = py_adv;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so that the registered
        // address/colour/plot line up with the state they belong to.
        plot_d  = (state_d == S_ERASE) || (state_d == S_DRAW);
        busy_d  = (state_d == S_ERASE) || (state_d == S_MOVE) ||
                  (state_d == S_CHECK) || (state_d == S_DRAW);
        col_d   = col_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        if (state_d == S_ERASE) begin
            col_d = BG_COL;
        end else if (state_d == S_DRAW) begin
            col_d = SPRITE_COL;
        end
        if ((state_d == S_ERASE) || (state_d == S_CHECK) || (state_d == S_DRAW)) begin
            x_out_d = pos_x_d + 8'(px_d);
            y_out_d = pos_y_d + 7'(py_d);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            tail_q  <= 1'b0;
            pos_x_q <= 8'(X_START);
            pos_y_q <= 7'(Y_GROUND);
            air_q   <= '0;
            coll_q  <= 1'b0;
            end_q   <= 1'b0;
            plot_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tail_q  <= tail_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            air_q   <= air_d;
            coll_q  <= coll_d;
            end_q   <= end_d;
            plot_q  <= plot_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
        end
    end

    assign plot               = plot_q;
    assign x_out              = x_out_q;
    assign y_out              = y_out_q;
    assign colour_out         = col_q;
    assign collided           = coll_q;
    assign reached_screen_end = end_q;
    assign busy               = busy_q;

`ifdef RUNNER_SCORE_EN
    logic       run_load;
    logic       draw_to_wait;
    logic [7:0] score_q, score_d;

    assign run_load     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign draw_to_wait = (state_q == S_DRAW) && scan_last && !coll_q && !end_q;

    always_comb begin
        score_d = score_q;
        if (run_load) begin
            score_d = '0;
        end else if (draw_to_wait && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

endmodule

// File: tb/tb_runner_frame_sequencer.sv
// Testbench for runner_frame_sequencer. Frame-level reference model
// (position, jump arc, obstacle overlap) builds the expected per-cycle trace
// of plot/busy/address/colour, compared against what the DUT produces.
// An obstacle map stands in for the framebuffer read port (1-cycle latency).

module tb_runner_frame_sequencer;

    localparam int SIZE       = 4;
    localparam int X_START    = 0;
    localparam int Y_GROUND   = 100;
    localparam int X_END      = 156;
    localparam int STEP       = 1;
    localparam int JUMP_H     = 12;
    localparam int AIR_FRAMES = 16;
    localparam logic [2:0] SPRITE_COL = 3'b110;
    localparam logic [2:0] BG_COL     = 3'b000;
    localparam logic [2:0] OBST_COL   = 3'b010;
    localparam int NSCAN     = SIZE * SIZE;
    localparam int FRAME_CYC = 3 * NSCAN + 3;
`ifdef RUNNER_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic       clock;
    logic       resetn, start, jump, frame_tick;
    logic [2:0] pix_colour;
    logic       plot, collided, reached_screen_end, busy;
    logic [7:0] x_out, score;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    runner_frame_sequencer dut (
        .clock(clock), .resetn(resetn), .start(start), .jump(jump),
        .frame_tick(frame_tick), .pix_colour(pix_colour), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .collided(collided), .reached_screen_end(reached_screen_end),
        .busy(busy), .score(score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    bit obst [0:159][0:119];
    always @(posedge clock)
        pix_colour <= (x_out < 8'd160 && y_out < 7'd120 && obst[x_out][y_out]) ? OBST_COL : BG_COL;

    logic       obs_plot[FRAME_CYC], obs_busy[FRAME_CYC];
    logic [7:0] obs_x[FRAME_CYC];
    logic [6:0] obs_y[FRAME_CYC];
    logic [2:0] obs_col[FRAME_CYC];
    logic       exp_plot[FRAME_CYC], exp_busy[FRAME_CYC];
    logic [7:0] exp_x[FRAME_CYC];
    logic [6:0] exp_y[FRAME_CYC];
    logic [2:0] exp_col[FRAME_CYC];

    int m_x, m_y, m_air, m_score;
    bit m_coll, m_end, m_done;
    int passed = 0;
    int total  = 0;

    function automatic logic [7:0] exp_score();
        return SCORE_EN ? 8'(m_score) : 8'd0;
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            obs_plot[i] = plot;  obs_busy[i] = busy;
            obs_x[i] = x_out;    obs_y[i] = y_out;  obs_col[i] = colour_out;
            @(negedge clock);
        end
    endtask

    task automatic exp_scan(input int base, input int ox, input int oy, input logic [2:0] col);
        for (int i = 0; i < NSCAN; i++) begin
            exp_plot[base+i] = 1'b1;  exp_busy[base+i] = 1'b1;
            exp_x[base+i] = 8'(ox + i % SIZE);
            exp_y[base+i] = 7'(oy + i / SIZE);
            exp_col[base+i] = col;
        end
    endtask

    task automatic exp_quiet();
        for (int i = 0; i < FRAME_CYC; i++) begin
            exp_plot[i] = 1'b0;  exp_busy[i] = 1'b0;
        end
    endtask

    // Erase old square, 1 move + (NSCAN+1) check cycles, draw new square, rest.
    task automatic exp_frame(input int ox, input int oy, input int nx, input int ny);
        exp_scan(0, ox, oy, BG_COL);
        for (int c = NSCAN; c < 2 * NSCAN + 2; c++) begin
            exp_plot[c] = 1'b0;  exp_busy[c] = 1'b1;
        end
        exp_scan(2 * NSCAN + 2, nx, ny, SPRITE_COL);
        exp_plot[FRAME_CYC-1] = 1'b0;  exp_busy[FRAME_CYC-1] = 1'b0;
    endtask

    task automatic exp_start_draw();
        m_x = X_START;  m_y = Y_GROUND;  m_air = 0;  m_score = 0;
        m_coll = 1'b0;  m_end = 1'b0;    m_done = 1'b0;
        exp_scan(0, X_START, Y_GROUND, SPRITE_COL);
        exp_plot[NSCAN] = 1'b0;  exp_busy[NSCAN] = 1'b0;
    endtask

    function automatic int trace_bad(input int n);
        int bad = 0;
        for (int c = 0; c < n; c++) begin
            if (obs_plot[c] !== exp_plot[c] || obs_busy[c] !== exp_busy[c]) bad++;
            else if (exp_plot[c] && (obs_x[c] !== exp_x[c] || obs_y[c] !== exp_y[c] ||
                                     obs_col[c] !== exp_col[c])) bad++;
        end
        return bad;
    endfunction

    function automatic bit square_hits(input int sx, input int sy);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                if (obst[sx+i][sy+j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_frame(input bit jmp);
        int ox, oy;
        ox = m_x;  oy = m_y;
        if (m_done) begin
            exp_quiet();
        end else begin
            m_x = (m_x + STEP >= X_END) ? X_END : m_x + STEP;
            if (m_x == X_END) m_end = 1'b1;
            if (m_air == 0 && jmp) begin
                m_y = Y_GROUND - JUMP_H;  m_air = AIR_FRAMES;
            end else if (m_air > 0) begin
                m_air--;
                if (m_air == 0) m_y = Y_GROUND;
            end
            if (square_hits(m_x, m_y)) m_coll = 1'b1;
            if (m_coll || m_end) m_done = 1'b1;
            else if (m_score < 255) m_score++;
            exp_frame(ox, oy, m_x, m_y);
        end
    endtask

    task automatic run_frame(input bit jmp);
        jump = jmp;
        model_frame(jmp);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        capture(FRAME_CYC);
    endtask

    task automatic begin_run(input int tick_at);
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) obst[i][j] = 1'b0;
        resetn = 1'b0;  start = 1'b0;  frame_tick = 1'b0;  jump = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_start_draw();
        for (int i = 0; i <= NSCAN; i++) begin
            frame_tick = (i == tick_at);
            obs_plot[i] = plot;  obs_busy[i] = busy;
            obs_x[i] = x_out;    obs_y[i] = y_out;  obs_col[i] = colour_out;
            @(negedge clock);
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;  start = 1'b0;  jump = 1'b0;  frame_tick = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", plot); else passed++;
        total++; if (x_out !== 8'd0 || y_out !== 7'd0) $display("FAIL reset_xy: got %0d,%0d want 0,0", x_out, y_out); else passed++;
        total++; if (colour_out !== 3'd0) $display("FAIL reset_colour: got %b want 000", colour_out); else passed++;
        total++; if (collided !== 1'b0 || reached_screen_end !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", collided, reached_screen_end); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (score !== 8'd0) $display("FAIL reset_score: got %0d want 0", score); else passed++;
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        total++; if (plot !== 1'b0 || busy !== 1'b0) $display("FAIL idle_quiet: got plot=%b busy=%b want 0 0", plot, busy); else passed++;
    endtask

    task automatic test_first_draw();
        int bad;
        begin_run(-1);
        bad = trace_bad(NSCAN + 1);
        total++; if (bad !== 0) $display("FAIL first_draw: got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_frames();
        int bad;
        begin_run(-1);
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0);
            bad = trace_bad(FRAME_CYC);
            total++; if (bad !== 0) $display("FAIL frame%0d_trace: got %0d bad cycles want 0", f, bad); else passed++;
            total++; if (collided !== 1'b0) $display("FAIL frame%0d_collided: got %b want 0", f, collided); else passed++;
            total++; if (score !== exp_score()) $display("FAIL frame%0d_score: got %0d want %0d", f, score, exp_score()); else passed++;
        end
    endtask

    task automatic test_collision();
        int bad;
        begin_run(-1);
        obst[5][102] = 1'b1;
        run_frame(1'b0);
        run_frame(1'b0);
        bad = trace_bad(FRAME_CYC);
        total++; if (bad !== 0) $display("FAIL coll_trace: got %0d bad cycles want 0", bad); else passed++;
        total++; if (collided !== m_coll) $display("FAIL coll_flag: got %b want %b", collided, m_coll); else passed++;
        total++; if (score !== exp_score()) $display("FAIL coll_score: got %0d want %0d", score, exp_score()); else passed++;
        run_frame(1'b0);
        bad = trace_bad(FRAME_CYC);
        total++; if (bad !== 0) $display("FAIL done_ignores_tick: got %0d bad cycles want 0", bad); else passed++;
        obst[5][102] = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        exp_start_draw();
        capture(NSCAN + 1);
        bad = trace_bad(NSCAN + 1);
        total++; if (bad !== 0) $display("FAIL restart_draw: got %0d bad cycles want 0", bad); else passed++;
        total++; if (collided !== 1'b0 || score !== 8'd0) $display("FAIL restart_clear: got coll=%b score=%0d want 0 0", collided, score); else passed++;
    endtask

    task automatic test_screen_end();
        int bad_frames = 0;
        begin_run(-1);
        for (int f = 0; f < (X_END - X_START) / STEP; f++) begin
            run_frame(1'b0);
            if (trace_bad(FRAME_CYC) != 0 || reached_screen_end !== m_end || collided !== 1'b0)
                bad_frames++;
        end
        total++; if (bad_frames !== 0) $display("FAIL run_to_end: got %0d bad frames want 0", bad_frames); else passed++;
        total++; if (reached_screen_end !== 1'b1) $display("FAIL end_flag: got %b want 1", reached_screen_end); else passed++;
        total++; if (obs_x[3*NSCAN+1] !== 8'(X_END + SIZE - 1)) $display("FAIL end_last_x: got %0d want %0d", obs_x[3*NSCAN+1], X_END + SIZE - 1); else passed++;
        total++; if (score !== exp_score()) $display("FAIL end_score: got %0d want %0d", score, exp_score()); else passed++;
        run_frame(1'b0);
        total++; if (trace_bad(FRAME_CYC) !== 0) $display("FAIL end_ignores_tick: got plot activity want none"); else passed++;
    endtask

    task automatic test_jump();
        int bad_frames = 0;
        begin_run(-1);
        for (int f = 1; f <= 20; f++) begin
            run_frame(f <= 17);
            if (trace_bad(FRAME_CYC) != 0) bad_frames++;
            if (f == 1 || f == 16) begin
                total++; if (obs_y[2*NSCAN+2] !== 7'(Y_GROUND - JUMP_H)) $display("FAIL jump_air_f%0d: got y=%0d want %0d", f, obs_y[2*NSCAN+2], Y_GROUND - JUMP_H); else passed++;
            end
            if (f == 17) begin
                total++; if (obs_y[2*NSCAN+2] !== 7'(Y_GROUND)) $display("FAIL jump_land: got y=%0d want %0d", obs_y[2*NSCAN+2], Y_GROUND); else passed++;
            end
        end
        total++; if (bad_frames !== 0) $display("FAIL jump_traces: got %0d bad frames want 0", bad_frames); else passed++;
        jump = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        begin_run(-1);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (plot !== 1'b1 || colour_out !== BG_COL) $display("FAIL mid_erase: got plot=%b col=%b want 1 000", plot, colour_out); else passed++;
        resetn = 1'b0;
        @(negedge clock);
        total++; if (plot !== 1'b0 || busy !== 1'b0 || x_out !== 8'd0) $display("FAIL mid_reset: got plot=%b busy=%b x=%0d want 0 0 0", plot, busy, x_out); else passed++;
        total++; if (collided !== 1'b0 || reached_screen_end !== 1'b0) $display("FAIL mid_reset_flags: got %b%b want 00", collided, reached_screen_end); else passed++;
        resetn = 1'b1;
        m_done = 1'b1;
        run_frame(1'b0);
        bad = trace_bad(FRAME_CYC);
        total++; if (bad !== 0) $display("FAIL idle_ignores_tick: got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_tick_in_draw();
        int bad;
        begin_run(5);
        bad = trace_bad(NSCAN + 1);
        total++; if (bad !== 0) $display("FAIL draw_with_tick: got %0d bad cycles want 0", bad); else passed++;
        exp_quiet();
        capture(20);
        bad = trace_bad(20);
        total++; if (bad !== 0) $display("FAIL tick_dropped: got %0d bad cycles want 0", bad); else passed++;
        run_frame(1'b0);
        bad = trace_bad(FRAME_CYC);
        total++; if (bad !== 0) $display("FAIL next_tick_frame: got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_random();
        int bad_frames, frames, ox, oy;
        for (int r = 0; r < 3; r++) begin
            begin_run(-1);
            for (int k = 0; k < 6; k++) begin
                ox = $urandom_range(150, 8);
                oy = $urandom_range(103, 86);
                obst[ox][oy] = 1'b1;
            end
            bad_frames = 0;
            frames = 0;
            while (!m_done && frames < 170) begin
                run_frame($urandom_range(7, 0) == 0);
                frames++;
                if (trace_bad(FRAME_CYC) != 0 || collided !== m_coll ||
                    reached_screen_end !== m_end || score !== exp_score())
                    bad_frames++;
            end
            total++; if (bad_frames !== 0) $display("FAIL random_run%0d: got %0d bad of %0d frames want 0", r, bad_frames, frames); else passed++;
        end
    endtask

    initial begin
        resetn = 1'b0;  start = 1'b0;  jump = 1'b0;  frame_tick = 1'b0;
        @(negedge clock);
        test_reset();
        test_first_draw();
        test_frames();
        test_collision();
        test_screen_end();
        test_jump();
        test_reset_mid();
        test_tick_in_draw();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
